// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receive controller that steers an external
// shift register and hands each complete frame to a ready/valid consumer.
module uart_rx_ctrl #(
    parameter int PACKET_SIZE = 8,
    parameter int CYCLE_DIV   = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic [PACKET_SIZE-1:0] reg_data,
    output logic                   LD,
    output logic                   msbLD,
    output logic [1:0]             shift,
    output logic                   sample,
    output logic [PACKET_SIZE-1:0] data_out,
    output logic                   valid,
    input  logic                   ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);
    localparam int CW = $clog2(CYCLE_DIV);
    localparam int BW = $clog2(PACKET_SIZE + 1);
    localparam logic [CW-1:0] HALF = CW'(CYCLE_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLE_DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(PACKET_SIZE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bitn_q;
    logic [1:0]             sync_q;
    logic                   err_wait_q, shift_en_q, sample_q, valid_q, frame_err_q, overrun_q, busy_q;
    logic [PACKET_SIZE-1:0] data_q;
    logic                   rxs;

    assign rxs       = sync_q[1];
    assign LD        = shift_en_q;
    assign msbLD     = shift_en_q;
    assign shift     = {1'b0, shift_en_q};
    assign sample    = sample_q;
    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

    // Control outputs trail the state by one cycle so they line up with the registered sample pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            sync_q      <= 2'b11;
            err_wait_q  <= 1'b0;
            shift_en_q  <= 1'b0;
            sample_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx};
            shift_en_q  <= (state_q == DATA);
            busy_q      <= (state_q != IDLE);
            sample_q    <= 1'b0;
            frame_err_q <= 1'b0;
            if (valid_q && ready) valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        sample_q <= 1'b1;
                        cnt_q    <= '0;
                        bitn_q   <= '0;
                        state_q  <= rxs ? IDLE : DATA;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        sample_q <= 1'b1;
                        cnt_q    <= '0;
                        bitn_q   <= bitn_q + 1'b1;
                        if (bitn_q == BLAST) state_q <= STOP;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                STOP: begin
                    if (err_wait_q) begin
                        if (rxs) begin
                            err_wait_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end else if (cnt_q == LAST) begin
                        sample_q <= 1'b1;
                        cnt_q    <= '0;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
                            err_wait_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            if (!valid_q || ready) begin
                                data_q  <= reg_data;
                                valid_q <= 1'b1;
                            end else overrun_q <= 1'b1;
                        end
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against uart_rx_ctrl with a behavioural
// right-shift register feeding reg_data.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, ready = 1'b1;
    logic [7:0] reg_data, data_out, sr = '0;
    logic       LD, msbLD, sample, valid, frame_err, overrun, busy;
    logic [1:0] shift;
    int         errors = 0, checks = 0, cyc = 0, t0 = 0;
    logic       clr = 1'b0, valid_prev = 1'b0;
    int         n_samp, n_dsamp, n_ld, n_ferr, n_vcyc, n_busy, vrise;

    uart_rx_ctrl #(.PACKET_SIZE(8), .CYCLE_DIV(100)) dut (
        .clk(clk), .reset(reset), .rx(rx), .reg_data(reg_data), .LD(LD), .msbLD(msbLD),
        .shift(shift), .sample(sample), .data_out(data_out), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External receive shift register: LSB-first data enters at the MSB and moves right.
    always @(posedge clk)
        if (sample && LD && msbLD && shift == 2'd1) sr <= {rx, sr[7:1]};
    assign reg_data = sr;

    always @(negedge clk) begin
        if (clr) begin
            n_samp = 0; n_dsamp = 0; n_ld = 0; n_ferr = 0; n_vcyc = 0; n_busy = 0; vrise = 0;
        end else begin
            if (sample) n_samp++;
            if (sample && LD) n_dsamp++;
            if (LD) n_ld++;
            if (frame_err) n_ferr++;
            if (valid) n_vcyc++;
            if (busy) n_busy++;
            if (valid && !valid_prev && vrise == 0) vrise = cyc;
        end
        valid_prev = valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        t0 = cyc;
        tick(100);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(100);
        end
        rx = stop;
        tick(100);
    endtask

    task automatic wait_ld(input logic lvl, input string tag);
        int n = 0;
        while (LD !== lvl && n < 2000) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < 2000), 1);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ctrl", {27'd0, LD, msbLD, shift, sample}, 0);
        chk("rst_flags", {30'd0, frame_err, overrun}, 0);
        tick(5);

        clear_counts();
        send(8'hA5, 1'b1);
        tick(20);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_dsamples", 32'(n_dsamp), 8);
        chk("a5_valid_cycles", 32'(n_vcyc), 1);
        chk("a5_ferr", 32'(n_ferr), 0);
        chk("a5_latency_ok", 32'(vrise - t0 >= 951 && vrise - t0 <= 953), 1);
        chk("a5_valid_now", 32'(valid), 0);

        clear_counts();
        rx = 1'b0;
        tick(30);
        rx = 1'b1;
        tick(120);
        chk("glitch_samples", 32'(n_samp), 1);
        chk("glitch_ld", 32'(n_ld), 0);
        chk("glitch_valid", 32'(n_vcyc), 0);
        chk("glitch_left_idle", 32'(n_busy > 0), 1);
        chk("glitch_busy_now", 32'(busy), 0);

        clear_counts();
        send(8'h3C, 1'b0);
        tick(200);
        chk("ferr_pulses", 32'(n_ferr), 1);
        chk("ferr_valid", 32'(n_vcyc), 0);
        chk("ferr_held_busy", 32'(busy), 1);
        chk("ferr_data_kept", 32'(data_out), 32'hA5);
        rx = 1'b1;
        tick(10);
        chk("ferr_idle_after", 32'(busy), 0);

        ready = 1'b0;
        send(8'h11, 1'b1);
        tick(20);
        chk("ovr_first_valid", 32'(valid), 1);
        chk("ovr_first_data", 32'(data_out), 32'h11);
        chk("ovr_first_flag", 32'(overrun), 0);
        send(8'h22, 1'b1);
        tick(20);
        chk("ovr_data_kept", 32'(data_out), 32'h11);
        chk("ovr_valid", 32'(valid), 1);
        chk("ovr_flag", 32'(overrun), 1);
        ready = 1'b1;
        tick(1);
        chk("ovr_consumed", 32'(valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        tick(20);

        rx = 1'b0;
        tick(100);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(100);
        end
        rx = 1'b0;
        tick(80);
        chk("mid_in_data", {30'd0, busy, LD}, 3);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_outs", {27'd0, LD, msbLD, shift, sample}, 0);
        chk("mid_rst_flags", {28'd0, valid, frame_err, overrun, busy}, 0);
        chk("mid_rst_data", 32'(data_out), 0);
        reset = 1'b0;
        rx = 1'b1;
        clear_counts();
        tick(1200);
        chk("mid_no_ferr", 32'(n_ferr), 0);
        chk("mid_no_valid", 32'(n_vcyc), 0);
        send(8'h5A, 1'b1);
        tick(20);
        chk("after_rst_data", 32'(data_out), 32'h5A);
        chk("after_rst_ovr", 32'(overrun), 0);

        ready = 1'b0;
        send(8'h77, 1'b1);
        tick(20);
        chk("sim_first_valid", 32'(valid), 1);
        fork
            send(8'hC3, 1'b1);
        join_none
        wait_ld(1'b1, "sim_ld_rise");
        wait_ld(1'b0, "sim_ld_fall");
        tick(98);
        ready = 1'b1;
        tick(1);
        chk("sim_stop_sample", 32'(sample), 1);
        chk("sim_valid_kept", 32'(valid), 1);
        chk("sim_data_new", 32'(data_out), 32'hC3);
        chk("sim_no_overrun", 32'(overrun), 0);
        tick(1);
        chk("sim_consumed", 32'(valid), 0);
        tick(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 8, meaning data bits per frame (LSB first).
REQ-002 SHALL have parameter CYCLE_DIV, default 100, meaning clk cycles per bit period.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port reg_data  input  PACKET_SIZE  parallel value from the receive shift register.
REQ-007 SHALL have port LD  output  1  shift-register load enable.
REQ-008 SHALL have port msbLD  output  1  load the incoming bit into the MSB slot.
REQ-009 SHALL have port shift  output  2  shift-register mode: 0=none, 1=right, 2=left.
REQ-010 SHALL have port sample  output  1  one-cycle pulse at each bit-centre sample.
REQ-011 SHALL have port data_out  output  PACKET_SIZE  latched received word.
REQ-012 SHALL have port valid  output  1  data_out holds an unconsumed word.
REQ-013 SHALL have port ready  input  1  consumer accepts data_out when valid&ready.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-015 SHALL have port overrun  output  1  sticky flag: a frame was dropped.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-018 SHALL implement an FSM with states IDLE, START, DATA, STOP, and a bit-period counter cnt counting 0..CYCLE_DIV-1, sized ceil(log2(CYCLE_DIV)).
REQ-019 IDLE: when rxs==0, SHALL clear cnt and go to START the next cycle.
REQ-020 START: at cnt==CYCLE_DIV/2-1, SHALL pulse sample; if rxs==1 (glitch), return to IDLE; otherwise clear cnt, clear bit counter bitn, and go to DATA.
REQ-021 DATA: SHALL pulse sample at cnt==CYCLE_DIV-1 and increment bitn; after the PACKET_SIZE-th sample, go to STOP with cnt cleared.
REQ-022 DATA: LD=1, msbLD=1, shift=1 SHALL be held constant for the whole state; in every other state LD=0, msbLD=0, shift=0.
REQ-023 STOP: at cnt==CYCLE_DIV-1, SHALL pulse sample.
REQ-024 STOP sample with rxs==1 and (valid==0 or ready==1): SHALL latch data_out<=reg_data and set valid=1 on the next cycle.
REQ-025 STOP sample with rxs==1, valid==1 and ready==0: SHALL leave data_out unchanged, drop the frame, and set overrun=1.
REQ-026 STOP sample with rxs==0: SHALL pulse frame_err for one cycle, leave valid/data_out unchanged, then go to IDLE only once rxs==1 (no false start on a held-low line).
REQ-027 After a good STOP sample, SHALL return to IDLE the next cycle.
REQ-028 valid SHALL clear on the cycle after valid&ready; a simultaneous new latch (REQ-024) SHALL keep valid=1 with the new data.
REQ-029 overrun SHALL stay set until reset.
REQ-030 Frame latency SHALL be: falling edge at rxs to valid = CYCLE_DIV/2 + (PACKET_SIZE+1)*CYCLE_DIV + 2 cycles, ±1.

Reset
REQ-031 On reset: state=IDLE, cnt=0, bitn=0, LD=0, msbLD=0, shift=0, sample=0, data_out=0, valid=0, frame_err=0, overrun=0, busy=0; the synchronizer presets to 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err; reception restarts on the next falling edge after reset deasserts.

Verification
REQ-033 Frame 0xA5 (8N1, CYCLE_DIV=100), ready=1 -> data_out=0xA5, valid=1 for one cycle, exactly 8 sample pulses in DATA, frame_err=0.
REQ-034 rx low pulse of 30 cycles from idle -> START then IDLE, one sample pulse, LD never asserted, valid=0.
REQ-035 Frame 0x3C with the stop bit driven 0 -> frame_err pulse, valid=0; the FSM stays out of IDLE until rx returns high.
REQ-036 Frames 0x11 then 0x22 with ready=0 -> data_out=0x11, valid=1, overrun=1; after ready=1, valid clears.
REQ-037 Reset asserted in DATA at bit 4 -> all outputs at reset values the next cycle; a following frame 0x5A is received correctly.
REQ-038 ready held 1 while a new frame completes on the same cycle valid is consumed -> data_out updates, valid stays 1, no overrun.
